fetch_stage: RTL

Instruction-fetch (IF) stage of the 16-bit pipelined processor, directly upstream of decode. Owns the program counter and drives the instruction-memory read port (`im_addr`/`im_rd`). Captures each fetched word into the IF/ID pipeline register. Handles start, stall, branch redirect and HALT detection; it stops fetching once a HALT opcode has been fetched.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/fetch_stage_if.sv | 12 +
 rtl/if_id_reg.sv | 43 ++++
 rtl/fetch_stage.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-FSM state encoding, opcode field layout
// and the bubble instruction used by the IF/ID and ID/EX registers.
package pipe_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam int         OP_MSB       = 15;
  localparam int         OP_WIDTH_DEF = 4;
  localparam logic [3:0] HALT_OP_DEF  = 4'hF;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port between the fetch stage (master) and the IM (slave).
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] im_addr;
  logic                  im_rd;
  logic [DATA_WIDTH-1:0] im_r_data;

  modport master (output im_addr, output im_rd, input  im_r_data);
  modport slave  (input  im_addr, input  im_rd, output im_r_data);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new word, hold, or squash to a bubble.
// Squash clears only the valid bit so the last instruction/PC stay visible.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_squash,
  input  logic [DATA_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_valid;

  // squash wins over load; neither means hold
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_instr <= DATA_WIDTH'(NOP_INSTR);
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_squash) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IDLE/FETCH/HALT control, fetch counter and
// the IF/ID register. Redirect beats stall; a fetched HALT word stops fetch.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    OP_WIDTH   = OP_WIDTH_DEF,
  parameter logic [OP_WIDTH-1:0]   HALT_OP    = OP_WIDTH'(HALT_OP_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_stage_if.master         im,
  output logic [DATA_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic                  if_id_valid,
  output logic                  fetch_halted,
  output logic [15:0]           fetch_cnt
);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_halted;
  logic [15:0]           r_cnt;

  logic [ADDR_WIDTH-1:0] w_pc_inc;
  logic                  w_is_halt;
  logic                  w_load;
  logic                  w_squash;

  assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);
  assign w_is_halt = (im.im_r_data[OP_MSB -: OP_WIDTH] == HALT_OP);

  // state, PC and capture counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_pc     <= '0;
      r_halted <= 1'b0;
      r_cnt    <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (redirect) begin
            r_pc <= redirect_pc;
          end else if (!stall) begin
            r_pc <= w_pc_inc;
            if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            if (w_is_halt) begin
              r_state  <= ST_HALT;
              r_halted <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          // a redirect here undoes a speculatively fetched HALT
          if (redirect) begin
            r_pc     <= redirect_pc;
            r_state  <= ST_FETCH;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID control: capture in FETCH, bubble on redirect or when not fetching
  always_comb begin
    w_load   = 1'b0;
    w_squash = 1'b0;
    if ((r_state == ST_FETCH) && !redirect && !stall) begin
      w_load = 1'b1;
    end else if ((redirect && (r_state != ST_IDLE)) || (!stall && (r_state != ST_FETCH))) begin
      w_squash = 1'b1;
    end else begin
      w_squash = 1'b0;
    end
  end

  if_id_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_squash (w_squash),
    .i_instr  (im.im_r_data),
    .i_pc     (w_pc_inc),
    .o_instr  (if_id_instr),
    .o_pc     (if_id_pc),
    .o_valid  (if_id_valid)
  );

  assign im.im_addr   = r_pc;
  assign im.im_rd     = (r_state == ST_FETCH) && !stall;
  assign fetch_halted = r_halted;
  assign fetch_cnt    = r_cnt;

endmodule
